ftoq: RTL and testbench

- Converts IEEE-754 single-precision floats back to signed 16-bit Q1.15 fixed point, i.e. result = round(f × 2^FRAC_BITS), saturated to the int16 range.
- It is the return path for the Q1.15→float converter: layer outputs computed in float go through it to the fixed-point datapath and memories.
- 3-stage pipeline with valid/ready backpressure, plus saturation and NaN status flags.

---
 rtl/ftoq.sv | 171 +++++++++++++++++
 tb/tb_ftoq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoq.sv
// ftoq: IEEE-754 float32 -> signed Q1.15 (generally Q(16-FRAC_BITS).FRAC_BITS)
// converter. It is the return path from float compute back into the
// fixed-point datapath: result = round(f * 2^FRAC_BITS), clamped to int16.
//
// Three pipeline stages behind one global enable (valid/ready backpressure):
//   1 unpack/classify   2 align (shift, guard, sticky)   3 round/saturate/sign
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, ACTIVE-HIGH (legacy name), clears valids/outputs
//   data_in    float32 {sign, exp[7:0], mant[22:0]}, with valid_in / ready_out
//   data_out   signed 16-bit result, with valid_out / ready_in
//   sat_flag   result was clamped (qualified by valid_out)
//   nan_flag   input was NaN, result forced to 0 (qualified by valid_out)
module ftoq #(
  parameter int FRAC_BITS  = 15,
  parameter int ROUND_MODE = 1   // 0 = truncate toward zero, 1 = nearest-even
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [15:0] data_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        sat_flag,
  output logic        nan_flag
);

  // Right-shift that turns the 24-bit significand into an integer scaled by
  // 2^FRAC_BITS: r = R_BIAS - exp.
  localparam int R_BIAS = 127 + 23 - FRAC_BITS;

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        zero;     // zero or denormal, flushed without a flag
    logic [9:0]  rsh;      // two's complement shift amount
    logic [23:0] sig;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic        inf;
    logic        ovf;      // magnitude already out of int16 range
    logic [24:0] mag;      // 25 bits so the rounding carry survives
    logic        guard;
    logic        sticky;
  } s2_t;

  logic        en;
  logic [3:1]  vld_pipe_q, vld_pipe_d;
  s1_t         s1_q, s1_d;
  s2_t         s2_q, s2_d;
  logic [15:0] data_q, data_d;
  logic        sat_q, sat_d;
  logic        nan_q, nan_d;

  // Whole pipe freezes only when the output holds an untaken result.
  assign en        = ~(vld_pipe_q[3] & ~ready_in);
  assign ready_out = en;
  assign valid_out = vld_pipe_q[3];
  assign data_out  = data_q;
  assign sat_flag  = sat_q;
  assign nan_flag  = nan_q;

  // Accept happens exactly when en is high, so valid_in feeds the shift directly.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (en) vld_pipe_d = {vld_pipe_q[2:1], valid_in};
  end

  // Stage 1: unpack and classify.
  always_comb begin
    s1_d = s1_q;
    if (en) begin
      s1_d.sign = data_in[31];
      s1_d.nan  = (data_in[30:23] == 8'hFF) && (data_in[22:0] != '0);
      s1_d.inf  = (data_in[30:23] == 8'hFF) && (data_in[22:0] == '0);
      s1_d.zero = (data_in[30:23] == 8'h00);
      s1_d.rsh  = 10'(R_BIAS - int'(data_in[30:23]));
      s1_d.sig  = {1'b1, data_in[22:0]};
    end
  end

  // Stage 2: align. The significand is placed above 24 zero bits so one shift
  // yields integer part (top half), guard (bit 23) and sticky (bits 22:0).
  logic        s1_normal;
  logic        s1_in_range;
  logic [47:0] s1_ext;

  always_comb begin
    s2_d        = s2_q;
    s1_normal   = ~(s1_q.nan | s1_q.inf | s1_q.zero);
    s1_in_range = ~s1_q.rsh[9] && (s1_q.rsh != '0) && (s1_q.rsh < 10'd26);
    s1_ext      = {s1_q.sig, 24'd0} >> s1_q.rsh[5:0];
    if (en) begin
      s2_d.sign   = s1_q.sign;
      s2_d.nan    = s1_q.nan;
      s2_d.inf    = s1_q.inf;
      s2_d.ovf    = s1_normal && (s1_q.rsh[9] || (s1_q.rsh == '0));
      s2_d.mag    = '0;
      s2_d.guard  = 1'b0;
      s2_d.sticky = 1'b0;
      if (s1_normal && s1_in_range) begin
        s2_d.mag    = {1'b0, s1_ext[47:24]};
        s2_d.guard  = s1_ext[23];
        s2_d.sticky = |s1_ext[22:0];
      end
    end
  end

  // Stage 3: round, saturate, apply sign.
  logic        inc;
  logic [24:0] mag_r;

  always_comb begin
    data_d = data_q;
    sat_d  = sat_q;
    nan_d  = nan_q;
    inc    = (ROUND_MODE != 0) && s2_q.guard && (s2_q.sticky || s2_q.mag[0]);
    mag_r  = s2_q.mag + 25'(inc);
    if (en) begin
      data_d = 16'h0000;
      sat_d  = 1'b0;
      nan_d  = 1'b0;
      if (s2_q.nan) begin
        nan_d = 1'b1;
      end else if (s2_q.sign) begin
        // -32768 is representable, so only beyond it is a clamp.
        if (s2_q.inf || s2_q.ovf || (mag_r > 25'd32768)) begin
          data_d = 16'h8000;
          sat_d  = 1'b1;
        end else if (mag_r == 25'd32768) begin
          data_d = 16'h8000;
        end else begin
          data_d = -mag_r[15:0];   // -0 naturally becomes 0x0000
        end
      end else begin
        if (s2_q.inf || s2_q.ovf || (mag_r > 25'd32767)) begin
          data_d = 16'h7FFF;
          sat_d  = 1'b1;
        end else begin
          data_d = mag_r[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      data_q     <= '0;
      sat_q      <= 1'b0;
      nan_q      <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      data_q     <= data_d;
      sat_q      <= sat_d;
      nan_q      <= nan_d;
    end
  end

endmodule

// File: tb/tb_ftoq.sv
// Directed bench for ftoq: one round-to-nearest instance and one truncating
// instance share the same stimulus; each task checks its own scenario.
module tb_ftoq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b1;

  logic        ready_out, valid_out, sat_flag, nan_flag;
  logic [15:0] data_out;
  logic        ready_out0, valid_out0, sat0, nan0;
  logic [15:0] data_out0;

  int n_chk = 0;
  int n_fail = 0;

  // results captured by run_one
  logic [15:0] r_data, r_data0;
  logic        r_sat, r_nan, r_sat0, r_nan0, r_vo0;
  int          r_lat;

  always #5 clk = ~clk;

  ftoq #(.FRAC_BITS(15), .ROUND_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .ready_in(ready_in), .sat_flag(sat_flag), .nan_flag(nan_flag)
  );

  ftoq #(.FRAC_BITS(15), .ROUND_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out0), .data_out(data_out0), .valid_out(valid_out0),
    .ready_in(ready_in), .sat_flag(sat0), .nan_flag(nan0)
  );

  // Reference Q1.15 -> float32 conversion (exact; every int16 fits in 24 bits).
  function automatic logic [31:0] q15_to_f(input logic [15:0] q);
    int         v, a, p;
    logic       s;
    logic [31:0] am;
    if (q == 16'h0000) return 32'h0;
    v = int'($signed(q));
    s = (v < 0);
    a = s ? -v : v;
    p = 0;
    for (int b = 0; b < 17; b++) if (a[b]) p = b;
    am = 32'(a) << (23 - p);
    return {s, 8'(127 + p - 15), am[22:0]};
  endfunction

  // Drive one item into an idle pipe, wait (bounded) for the result.
  task automatic run_one(input logic [31:0] f);
    @(posedge clk); #1;
    data_in  = f;
    valid_in = 1'b1;
    ready_in = 1'b1;
    r_lat    = 0;
    do begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      r_lat++;
    end while (!valid_out && r_lat < 20);
    r_data  = data_out;  r_sat  = sat_flag; r_nan  = nan_flag;
    r_data0 = data_out0; r_sat0 = sat0;     r_nan0 = nan0; r_vo0 = valid_out0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({valid_out, data_out, sat_flag, nan_flag} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got vo=%b d=%h sat=%b nan=%b, expected all 0",
               valid_out, data_out, sat_flag, nan_flag);
    end
    n_chk++;
    if ({valid_out0, data_out0, sat0, nan0} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_rm0: got vo=%b d=%h, expected 0", valid_out0, data_out0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (ready_out !== 1'b1 || ready_out0 !== 1'b1 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got ready=%b/%b vo=%b, expected 1/1 0",
               ready_out, ready_out0, valid_out);
    end
    ready_in = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] vin [3];
    logic [15:0] vexp[3];
    vin  = '{32'h3F000000, 32'hBE800000, 32'h00000000};
    vexp = '{16'h4000,     16'hE000,     16'h0000};
    for (int i = 0; i < 3; i++) begin
      run_one(vin[i]);
      n_chk++;
      if ({r_data, r_sat, r_nan} !== {vexp[i], 2'b00}) begin
        n_fail++;
        $display("FAIL basic[%0d]: in=%h got d=%h sat=%b nan=%b, expected d=%h sat=0 nan=0",
                 i, vin[i], r_data, r_sat, r_nan, vexp[i]);
      end
      n_chk++;
      if (r_lat !== 3) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d cycles, expected 3", i, r_lat);
      end
    end
  endtask

  task automatic test_boundary;
    logic [31:0] vin [9];
    logic [17:0] vexp[9];   // {data, sat, nan}
    vin  = '{32'hBF800000, 32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
             32'h3F7FFFFF, 32'h00000001, 32'h80000000, 32'h47000000};
    vexp = '{{16'h8000, 2'b00}, {16'h7FFF, 2'b10}, {16'h7FFF, 2'b10}, {16'h8000, 2'b10},
             {16'h0000, 2'b01}, {16'h7FFF, 2'b10}, {16'h0000, 2'b00}, {16'h0000, 2'b00},
             {16'h7FFF, 2'b10}};
    for (int i = 0; i < 9; i++) begin
      run_one(vin[i]);
      n_chk++;
      if ({r_data, r_sat, r_nan} !== vexp[i]) begin
        n_fail++;
        $display("FAIL boundary[%0d]: in=%h got d=%h sat=%b nan=%b, expected d=%h sat=%b nan=%b",
                 i, vin[i], r_data, r_sat, r_nan, vexp[i][17:2], vexp[i][1], vexp[i][0]);
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] vin [7];
    logic [15:0] vexp1[7];
    logic [15:0] vexp0[7];
    vin   = '{32'h37800000, 32'h38400000, 32'h38200000, 32'hB7800000,
              32'hB8400000, 32'h38A00000, 32'h3F7FFFFF};
    vexp1 = '{16'h0000, 16'h0002, 16'h0001, 16'h0000, 16'hFFFE, 16'h0002, 16'h7FFF};
    vexp0 = '{16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'h0002, 16'h7FFF};
    for (int i = 0; i < 7; i++) begin
      run_one(vin[i]);
      n_chk++;
      if (r_data !== vexp1[i]) begin
        n_fail++;
        $display("FAIL round_rne[%0d]: in=%h got %h, expected %h", i, vin[i], r_data, vexp1[i]);
      end
      // truncation never clamps for these inputs
      n_chk++;
      if ({r_vo0, r_data0, r_sat0, r_nan0} !== {1'b1, vexp0[i], 2'b00}) begin
        n_fail++;
        $display("FAIL round_trunc[%0d]: in=%h got vo=%b d=%h sat=%b nan=%b, expected vo=1 d=%h flags 0",
                 i, vin[i], r_vo0, r_data0, r_sat0, r_nan0, vexp0[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin [4];
    logic [15:0] vexp[4];
    logic        exp_v;
    vin  = '{32'h3F000000, 32'hBE800000, 32'h38400000, 32'h3E000000};
    vexp = '{16'h4000,     16'hE000,     16'h0002,     16'h1000};
    ready_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      exp_v = (c >= 3 && c <= 6);
      n_chk++;
      if (valid_out !== exp_v || (exp_v && data_out !== vexp[c-3])) begin
        n_fail++;
        $display("FAIL b2b[c=%0d]: got vo=%b d=%h, expected vo=%b d=%h",
                 c, valid_out, data_out, exp_v, exp_v ? vexp[c-3] : 16'h0);
      end
      valid_in = (c < 4);
      data_in  = (c < 4) ? vin[c] : 32'h0;
      if (c < 4) begin
        #1;
        n_chk++;
        if (ready_out !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready[c=%0d]: got %b, expected 1", c, ready_out);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] vin [8];
    logic [15:0] vexp[8];
    int          idx, oi, cyc;
    logic        hold_chk;
    logic [15:0] held;
    vin  = '{32'h3F000000, 32'hBE800000, 32'h38400000, 32'h3E000000,
             32'hBF800000, 32'h7FC00000, 32'h3E800000, 32'hBD800000};
    vexp = '{16'h4000, 16'hE000, 16'h0002, 16'h1000,
             16'h8000, 16'h0000, 16'h2000, 16'hF800};
    idx = 0; oi = 0; cyc = 0; hold_chk = 1'b0; held = '0;
    while (oi < 8 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (hold_chk) begin
        n_chk++;
        if (valid_out !== 1'b1 || data_out !== held) begin
          n_fail++;
          $display("FAIL bp_hold[cyc=%0d]: got vo=%b d=%h, expected vo=1 d=%h",
                   cyc, valid_out, data_out, held);
        end
      end
      ready_in = !(cyc >= 4 && cyc <= 9);
      valid_in = (idx < 8);
      data_in  = (idx < 8) ? vin[idx] : 32'h0;
      #1;
      n_chk++;
      if (ready_out !== !(valid_out && !ready_in)) begin
        n_fail++;
        $display("FAIL bp_ready[cyc=%0d]: got %b, expected %b",
                 cyc, ready_out, !(valid_out && !ready_in));
      end
      if (valid_out && ready_in) begin
        n_chk++;
        if (data_out !== vexp[oi]) begin
          n_fail++;
          $display("FAIL bp_data[%0d]: got %h, expected %h", oi, data_out, vexp[oi]);
        end
        oi++;
      end
      hold_chk = valid_out && !ready_in;
      held     = data_out;
      if (valid_in && ready_out) idx++;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    n_chk++;
    if (oi !== 8) begin
      n_fail++;
      $display("FAIL bp_count: got %0d outputs, expected 8", oi);
    end
    // nothing extra may follow (no duplicates)
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_extra[c=%0d]: got vo=%b d=%h, expected vo=0", c, valid_out, data_out);
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [31:0] vin[3];
    vin = '{32'h3F000000, 32'hBE800000, 32'h3E000000};
    ready_in = 1'b0;   // keep the head item from being taken before the flush
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = vin[i];
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    rst_n    = 1'b0;
    ready_in = 1'b1;
    n_chk++;
    if (valid_out !== 1'b0 || data_out !== 16'h0000 || ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_flush: got vo=%b d=%h rdy=%b, expected vo=0 d=0000 rdy=1",
               valid_out, data_out, ready_out);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_ghost[c=%0d]: got vo=%b d=%h, expected vo=0", c, valid_out, data_out);
      end
    end
  endtask

  task automatic test_round_trip;
    int idx, oi, cyc;
    idx = 0; oi = 0; cyc = 0;
    ready_in = 1'b1;
    while (oi < 65536 && cyc < 65600) begin
      @(posedge clk); #1;
      cyc++;
      if (valid_out) begin
        n_chk++;
        if ({data_out, sat_flag, nan_flag} !== {16'(oi), 2'b00}) begin
          n_fail++;
          $display("FAIL round_trip[%0d]: in=%h got d=%h sat=%b nan=%b, expected d=%h no flags",
                   oi, q15_to_f(16'(oi)), data_out, sat_flag, nan_flag, 16'(oi));
        end
        oi++;
      end
      valid_in = (idx < 65536);
      data_in  = (idx < 65536) ? q15_to_f(16'(idx)) : 32'h0;
      if (idx < 65536) idx++;
    end
    valid_in = 1'b0;
    n_chk++;
    if (oi !== 65536) begin
      n_fail++;
      $display("FAIL round_trip_count: got %0d outputs, expected 65536", oi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_rounding();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_round_trip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
